// File: rtl/osd_ctm_mc.sv
// osd_ctm_mc: multi-core control-transfer trace. Each core gets its own FIFO and the FIFOs merge round-robin into one registered stream.
// Optional build macro OSD_CTM_MC_PRV_TRACE_EN adds privilege-change sampling.
module osd_ctm_mc #(
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int TS_WIDTH   = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 8,
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int EW  = CHW + 1 + CNT_WIDTH + 5 + 2 + 2*ADDR_WIDTH + TS_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall,
  input  logic [NUM_CH-1:0]            cfg_enable,
  input  logic [1:0]                   cfg_mode,
  input  logic [NUM_CH-1:0]            trace_valid,
  input  logic [NUM_CH-1:0]            trace_jal,
  input  logic [NUM_CH-1:0]            trace_jalr,
  input  logic [NUM_CH-1:0]            trace_branch,
  input  logic [NUM_CH-1:0]            trace_br_taken,
  input  logic [NUM_CH-1:0]            trace_mem,
  input  logic [2*NUM_CH-1:0]          trace_prv,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] trace_pc,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] trace_npc,
  output logic                         evt_valid,
  output logic [EW-1:0]                evt_data,
  input  logic                         evt_ready
);
  // Handshake: evt_valid/evt_data are registered; an event transfers on the
  // clk edge where evt_valid & evt_ready, and evt_data holds while evt_valid & !evt_ready.
  localparam int FW  = EW - CHW;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int PW1 = PW + 1;
  localparam logic [CNT_WIDTH-1:0] LOST_MAX = '1;

  logic [TS_WIDTH-1:0]  ts;
  logic [PW:0]          wr_ptr [NUM_CH];
  logic [PW:0]          rd_ptr [NUM_CH];
  logic [CNT_WIDTH-1:0] lost   [NUM_CH];
  logic [FW-1:0]        mem    [NUM_CH][FIFO_DEPTH];
  logic [CHW-1:0]       rr_ptr;

  logic [NUM_CH-1:0] prvchange, hit, sample, full, empty, push, pop;
  logic [FW-1:0]     entry [NUM_CH];
  logic              found, load;
  logic [CHW-1:0]    sel, sel_next;

`ifdef OSD_CTM_MC_PRV_TRACE_EN
  logic [1:0] prv_reg [NUM_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) prv_reg[c] <= 2'b11;
    end else begin
      for (int c = 0; c < NUM_CH; c++) prv_reg[c] <= trace_prv[2*c +: 2];
    end
  end

  always_comb begin
    prvchange = '0;
    for (int c = 0; c < NUM_CH; c++) prvchange[c] = (prv_reg[c] != trace_prv[2*c +: 2]);
  end
`else
  assign prvchange = '0;
`endif

  // Per-channel sampling and FIFO status. lost[c] is zero when nothing was
  // dropped, so it doubles as the lost_cnt field.
  always_comb begin
    logic mode_hit;
    hit    = '0;
    sample = '0;
    full   = '0;
    empty  = '0;
    push   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      mode_hit = 1'b0;
      case (cfg_mode)
        2'd1:    mode_hit = trace_jal[c] | trace_jalr[c] | (trace_branch[c] & trace_br_taken[c]);
        2'd2:    mode_hit = 1'b1;
        default: mode_hit = trace_jal[c] | trace_jalr[c];
      endcase
      hit[c]    = trace_valid[c] & ~trace_mem[c] & mode_hit;
      sample[c] = cfg_enable[c] & ~stall & (hit[c] | prvchange[c]);
      empty[c]  = (wr_ptr[c] == rd_ptr[c]);
      full[c]   = (wr_ptr[c][PW] != rd_ptr[c][PW]) &&
                  (wr_ptr[c][PW-1:0] == rd_ptr[c][PW-1:0]);
      push[c]   = sample[c] & ~full[c];
      entry[c]  = {(lost[c] != '0), lost[c], prvchange[c], trace_jal[c], trace_jalr[c],
                   trace_branch[c], trace_br_taken[c], trace_prv[2*c +: 2],
                   trace_pc[c*ADDR_WIDTH +: ADDR_WIDTH], trace_npc[c*ADDR_WIDTH +: ADDR_WIDTH], ts};
    end
  end

  // Round-robin pick: first non-empty channel at or after rr_ptr.
  always_comb begin
    int idx;
    found = 1'b0;
    sel   = '0;
    pop   = '0;
    idx   = 0;
    load  = ~evt_valid | evt_ready;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_CH;
      if (!found && !empty[idx]) begin
        found = 1'b1;
        sel   = CHW'(idx);
      end
    end
    sel_next = (int'(sel) == NUM_CH - 1) ? '0 : sel + CHW'(1);
    if (load && found) pop[sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push[c]) mem[c][wr_ptr[c][PW-1:0]] <= entry[c];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts        <= '0;
      rr_ptr    <= '0;
      evt_valid <= 1'b0;
      evt_data  <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        lost[c]   <= '0;
      end
    end else begin
      ts <= ts + TS_WIDTH'(1);
      for (int c = 0; c < NUM_CH; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + PW1'(1);
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + PW1'(1);
        // Full is judged on the pre-edge pointers, so a same-cycle read does not rescue the sample.
        if (sample[c] && full[c]) begin
          if (lost[c] != LOST_MAX) lost[c] <= lost[c] + CNT_WIDTH'(1);
        end else if (push[c]) begin
          lost[c] <= '0;
        end
      end
      if (load) begin
        evt_valid <= found;
        if (found) begin
          evt_data <= {sel, mem[sel][rd_ptr[sel][PW-1:0]]};
          rr_ptr   <= sel_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_osd_ctm_mc.sv
// Bench for osd_ctm_mc: per-channel expected queues filled at stimulus time,
// drained by a monitor on accepted events, plus per-scenario inline checks.
module tb_osd_ctm_mc;
  localparam int NUM_CH = 2;
  localparam int AW     = 32;
  localparam int TSW    = 32;
  localparam int DEPTH  = 8;
  localparam int CNTW   = 8;
  localparam int CHW    = 1;
  localparam int EW     = CHW + 1 + CNTW + 5 + 2 + 2*AW + TSW;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   stall = 1'b0;
  logic [NUM_CH-1:0]      cfg_enable = '1;
  logic [1:0]             cfg_mode = 2'd0;
  logic [NUM_CH-1:0]      trace_valid = '0, trace_jal = '0, trace_jalr = '0;
  logic [NUM_CH-1:0]      trace_branch = '0, trace_br_taken = '0, trace_mem = '0;
  logic [2*NUM_CH-1:0]    trace_prv = '1;
  logic [NUM_CH*AW-1:0]   trace_pc = '0, trace_npc = '0;
  logic                   evt_valid;
  logic [EW-1:0]          evt_data;
  logic                   evt_ready = 1'b0;

  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  int            ch_log[$];
  int            ev_seen [NUM_CH];
  int            n_checks = 0;
  int            n_pass = 0;
  logic [TSW-1:0] ts_m;
  logic [EW-1:0]  mon_exp;
  int             mon_ch;
  bit             mon_has;

  osd_ctm_mc #(.NUM_CH(NUM_CH), .ADDR_WIDTH(AW), .TS_WIDTH(TSW),
               .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .cfg_enable(cfg_enable), .cfg_mode(cfg_mode),
    .trace_valid(trace_valid), .trace_jal(trace_jal), .trace_jalr(trace_jalr),
    .trace_branch(trace_branch), .trace_br_taken(trace_br_taken), .trace_mem(trace_mem),
    .trace_prv(trace_prv), .trace_pc(trace_pc), .trace_npc(trace_npc),
    .evt_valid(evt_valid), .evt_data(evt_data), .evt_ready(evt_ready)
  );

  // Clock / reset / reference timestamp
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_m <= '0;
    else        ts_m <= ts_m + 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  // Scoreboard monitor: an event seen valid&ready here is accepted at the next posedge.
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      mon_ch  = int'(evt_data[EW-1 -: CHW]);
      mon_has = 1'b0;
      ch_log.push_back(mon_ch);
      ev_seen[mon_ch]++;
      if (mon_ch == 0 && exp_q0.size() != 0) begin
        mon_exp = exp_q0.pop_front();
        mon_has = 1'b1;
      end else if (mon_ch == 1 && exp_q1.size() != 0) begin
        mon_exp = exp_q1.pop_front();
        mon_has = 1'b1;
      end
      n_checks++;
      if (!mon_has)
        $display("FAIL evt_unexpected ch=%0d got=%h exp=none", mon_ch, evt_data);
      else if (evt_data !== mon_exp)
        $display("FAIL evt_ch%0d got=%h exp=%h", mon_ch, evt_data, mon_exp);
      else
        n_pass++;
    end
  end

  // Driver tasks
  function automatic logic [EW-1:0] mk_evt(input int c, input logic ovf, input logic [CNTW-1:0] lc,
                                           input logic pch, j, jr, b, bt, input logic [1:0] p,
                                           input logic [AW-1:0] pc, npc, input logic [TSW-1:0] ts);
    logic [CHW-1:0] cc;
    cc = CHW'(c);
    return {cc, ovf, lc, pch, j, jr, b, bt, p, pc, npc, ts};
  endfunction

  task automatic push_exp(input int c, input logic [EW-1:0] e);
    if (c == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic set_ch(input int c, input logic v, j, jr, b, bt, m, input logic [1:0] p,
                        input logic [AW-1:0] pc, npc);
    trace_valid[c] = v;  trace_jal[c] = j;  trace_jalr[c] = jr;
    trace_branch[c] = b; trace_br_taken[c] = bt; trace_mem[c] = m;
    trace_prv[2*c +: 2] = p;
    trace_pc[c*AW +: AW] = pc;
    trace_npc[c*AW +: AW] = npc;
  endtask

  // Retire one instruction on channel c this cycle (prv 3); optionally expect an event.
  task automatic drive_ev(input int c, input logic j, jr, b, bt, m, input bit exp_ev,
                          input logic ovf, input logic [CNTW-1:0] lc);
    logic [AW-1:0] pc, npc;
    pc  = $urandom;
    npc = $urandom;
    set_ch(c, 1'b1, j, jr, b, bt, m, 2'b11, pc, npc);
    if (exp_ev) push_exp(c, mk_evt(c, ovf, lc, 1'b0, j, jr, b, bt, 2'b11, pc, npc, ts_m));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    trace_valid = '0; trace_jal = '0; trace_jalr = '0;
    trace_branch = '0; trace_br_taken = '0; trace_mem = '0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    evt_ready = 1'b1;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0 || evt_valid) && n < 200) begin
      step();
      n++;
    end
    repeat (4) step();
    n_checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0 || evt_valid !== 1'b0)
      $display("FAIL %s_drain got q0=%0d q1=%0d valid=%b exp=0,0,0", name, exp_q0.size(), exp_q1.size(), evt_valid);
    else
      n_pass++;
  endtask

  // Scenarios
  task automatic test_reset();
    n_checks++;
    if (evt_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", evt_valid);
    else n_pass++;
    n_checks++;
    if (evt_data !== '0) $display("FAIL reset_data got=%h exp=0", evt_data);
    else n_pass++;
  endtask

  task automatic test_latency();
    evt_ready = 1'b1;
    cfg_mode  = 2'd0;
    drive_ev(0, 1, 0, 0, 0, 0, 1'b1, 1'b0, '0);
    step();
    n_checks++;
    if (evt_valid !== 1'b0) $display("FAIL latency_t1 got=%b exp=0", evt_valid);
    else n_pass++;
    step();
    n_checks++;
    if (evt_valid !== 1'b1) $display("FAIL latency_t2 got=%b exp=1", evt_valid);
    else n_pass++;
    wait_drain("latency");
  endtask

  task automatic test_modes();
    int seen1;
    seen1 = ev_seen[1];
    cfg_mode = 2'd1;
    drive_ev(1, 0, 0, 1, 1, 0, 1'b1, 1'b0, '0); step();
    drive_ev(1, 0, 0, 1, 0, 0, 1'b0, 1'b0, '0); step();
    cfg_mode = 2'd0;
    drive_ev(1, 0, 0, 1, 1, 0, 1'b0, 1'b0, '0); step();
    wait_drain("mode01");
    n_checks++;
    if (ev_seen[1] - seen1 !== 1) $display("FAIL mode01_count got=%0d exp=1", ev_seen[1] - seen1);
    else n_pass++;
    cfg_mode = 2'd2;
    drive_ev(0, 0, 0, 0, 0, 0, 1'b1, 1'b0, '0); step();
    drive_ev(0, 1, 0, 0, 0, 1, 1'b0, 1'b0, '0); step();
    cfg_mode = 2'd3;
    drive_ev(1, 0, 0, 1, 1, 0, 1'b0, 1'b0, '0); step();
    drive_ev(1, 0, 1, 0, 0, 0, 1'b1, 1'b0, '0); step();
    wait_drain("mode23");
    cfg_mode = 2'd0;
  endtask

  task automatic test_enable_stall();
    int seen0;
    seen0 = ev_seen[0] + ev_seen[1];
    cfg_enable = 2'b10;
    drive_ev(0, 1, 0, 0, 0, 0, 1'b0, 1'b0, '0); step();
    cfg_enable = 2'b11;
    stall = 1'b1;
    drive_ev(0, 1, 0, 0, 0, 0, 1'b0, 1'b0, '0);
    drive_ev(1, 0, 1, 0, 0, 0, 1'b0, 1'b0, '0); step();
    stall = 1'b0;
    wait_drain("enable_stall");
    n_checks++;
    if (ev_seen[0] + ev_seen[1] !== seen0) $display("FAIL enable_stall_count got=%0d exp=0", ev_seen[0] + ev_seen[1] - seen0);
    else n_pass++;
  endtask

  // 12 jals with ready low: the output register takes the first, the FIFO the next 8,
  // the last 3 are lost and reported by the next enqueued entry.
  task automatic test_overflow();
    logic [EW-1:0] held;
    evt_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive_ev(0, 1, 0, 0, 0, 0, (i < 9), 1'b0, '0);
      step();
    end
    step();
    held = evt_data;
    n_checks++;
    if (evt_valid !== 1'b1) $display("FAIL ovf_valid_held got=%b exp=1", evt_valid);
    else n_pass++;
    repeat (3) step();
    n_checks++;
    if (evt_data !== held) $display("FAIL ovf_data_stable got=%h exp=%h", evt_data, held);
    else n_pass++;
    evt_ready = 1'b1;
    step();
    drive_ev(0, 1, 0, 0, 0, 0, 1'b1, 1'b1, 8'd3);
    step();
    wait_drain("overflow");
  endtask

  task automatic test_back_to_back();
    bit alt;
    ch_log.delete();
    evt_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_ev(0, 1, 0, 0, 0, 0, 1'b1, 1'b0, '0);
      drive_ev(1, 1, 0, 0, 0, 0, 1'b1, 1'b0, '0);
      step();
    end
    wait_drain("b2b");
    alt = (ch_log.size() == 12);
    for (int i = 1; i < ch_log.size(); i++) if (ch_log[i] == ch_log[i-1]) alt = 1'b0;
    n_checks++;
    if (!alt) $display("FAIL b2b_alternate got=len%0d exp=len12_alternating", ch_log.size());
    else n_pass++;
  endtask

  task automatic test_prv();
    int seen0;
    logic [AW-1:0] pc, npc;
    seen0 = ev_seen[0];
    pc = $urandom;
    npc = $urandom;
    set_ch(0, 1'b0, 0, 0, 0, 0, 0, 2'b00, pc, npc);
`ifdef OSD_CTM_MC_PRV_TRACE_EN
    push_exp(0, mk_evt(0, 1'b0, '0, 1'b1, 0, 0, 0, 0, 2'b00, pc, npc, ts_m));
`endif
    step();
    set_ch(0, 1'b0, 0, 0, 0, 0, 0, 2'b00, pc, npc);
    step();
    set_ch(0, 1'b0, 0, 0, 0, 0, 0, 2'b11, pc, npc);
`ifdef OSD_CTM_MC_PRV_TRACE_EN
    push_exp(0, mk_evt(0, 1'b0, '0, 1'b1, 0, 0, 0, 0, 2'b11, pc, npc, ts_m));
`endif
    step();
    wait_drain("prv");
    n_checks++;
`ifdef OSD_CTM_MC_PRV_TRACE_EN
    if (ev_seen[0] - seen0 !== 2) $display("FAIL prv_count got=%0d exp=2", ev_seen[0] - seen0);
`else
    if (ev_seen[0] - seen0 !== 0) $display("FAIL prv_count got=%0d exp=0", ev_seen[0] - seen0);
`endif
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    evt_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive_ev(0, 1, 0, 0, 0, 0, 1'b0, 1'b0, '0);
      step();
    end
    n_checks++;
    if (evt_valid !== 1'b1) $display("FAIL rstmid_pre_valid got=%b exp=1", evt_valid);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    #1;
    n_checks++;
    if (evt_valid !== 1'b0) $display("FAIL rstmid_valid got=%b exp=0", evt_valid);
    else n_pass++;
    n_checks++;
    if (evt_data !== '0) $display("FAIL rstmid_data got=%h exp=0", evt_data);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    evt_ready = 1'b1;
    repeat (10) step();
    drive_ev(0, 1, 0, 0, 0, 0, 1'b1, 1'b0, '0);
    step();
    wait_drain("rstmid");
  endtask

  initial begin
    for (int c = 0; c < NUM_CH; c++) ev_seen[c] = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_latency();
    test_modes();
    test_enable_stall();
    test_overflow();
    test_back_to_back();
    test_prv();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
